seg7_scan_display: RTL and testbench

Multiplexed 4-digit seven-segment display driver: the consumer of the button-driven number sources in the adder lab designs. Accepts a 16-bit hex value on a load strobe and applies it only at a scan-frame boundary, so digits never show a mixed old/new value. It scans one digit per refresh tick and decodes each nibble to active-low segments. It sits between the number/adder logic and the board's anode/segment pins.

---
 rtl/seg7_pkg.sv | 42 ++++
 rtl/seg7_scan_display_if.sv | 25 ++
 rtl/seg7_hex_decode.sv | 14 +
 rtl/seg7_scan_display.sv | 101 ++++++++++
 tb/tb_seg7_scan_display.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants, types and hex glyph table for the seven-segment display blocks
package seg7_pkg;

  // Segment and anode lines are active-low, so all-ones means dark.
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF    = 4'hF;

  localparam int NUM_DIGITS = 4;

  typedef logic [1:0] digit_idx_t;

  // One registered drive word for the board pins.
  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
  } drive_t;

  // Active-low g..a glyphs for hex digits 0-F (bit 0 = segment a).
  function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
    logic [6:0] g;
    case (nibble)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// rtl/seg7_scan_display_if.sv - value/strobe and pin bundle between number logic and the display driver
interface seg7_scan_display_if;

  logic [15:0] num;
  logic        load;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        ack;
  logic        pending;
  logic [3:0]  an;
  logic [7:0]  seg;

  // Number source side: supplies the value and per-digit controls.
  modport master (
    output num, load, dp, blank,
    input  ack, pending, an, seg
  );

  // Display driver side.
  modport slave (
    input  num, load, dp, blank,
    output ack, pending, an, seg
  );

endinterface

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational 4-bit to active-low 7-segment glyph decoder
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  // Pure table lookup so other display blocks can reuse the same glyph set.
  always_comb begin
    glyph = hex_glyph(nibble);
  end

endmodule

// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - multiplexed 4-digit display driver with frame-aligned value update
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  seg7_scan_display_if.slave   bus
);

  logic [DIV_W-1:0] prescale;
  logic             tick;
  digit_idx_t       idx;
  logic             boundary;

  logic [15:0]      staging;
  logic [15:0]      shown;
  logic             pending_q;
  logic             ack_q;

  logic [3:0]       nibble;
  logic [6:0]       glyph;
  drive_t           drive_next;
  drive_t           drive_q;

  assign tick     = &prescale;
  // Swapping the shown value only here keeps every frame internally consistent.
  assign boundary = tick && (idx == digit_idx_t'(NUM_DIGITS - 1));

  // Free-running prescaler; one full wrap is one digit slot.
  always_ff @(posedge clk) begin
    if (rst) prescale <= '0;
    else     prescale <= prescale + 1'b1;
  end

  // Digit scan index advances once per slot and wraps naturally at 3.
  always_ff @(posedge clk) begin
    if (rst)       idx <= '0;
    else if (tick) idx <= idx + 2'd1;
  end

  // Staging register: last load wins; a load coinciding with a boundary
  // lands here after the boundary has consumed the previous staged value.
  always_ff @(posedge clk) begin
    if (rst) begin
      staging   <= '0;
      pending_q <= 1'b0;
    end else begin
      if (boundary)  pending_q <= 1'b0;
      if (bus.load) begin
        staging   <= bus.num;
        pending_q <= 1'b1;
      end
    end
  end

  // Displayed value updates only at the frame boundary; ack marks a real handover.
  always_ff @(posedge clk) begin
    if (rst) begin
      shown <= '0;
      ack_q <= 1'b0;
    end else begin
      ack_q <= boundary && pending_q;
      if (boundary && pending_q) shown <= staging;
    end
  end

  assign nibble = shown[{idx, 2'b00} +: 4];

  seg7_hex_decode u_hex_decode (
    .nibble (nibble),
    .glyph  (glyph)
  );

  // Pin values for the current slot; dp and blank are taken live.
  always_comb begin
    drive_next.an  = AN_OFF;
    drive_next.seg = SEG_BLANK;
    if (!bus.blank[idx]) begin
      drive_next.an  = ~(4'b0001 << idx);
      drive_next.seg = {~bus.dp[idx], glyph};
    end
  end

  // Registered pin drive so the board sees glitch-free anode/segment lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      drive_q.an  <= AN_OFF;
      drive_q.seg <= SEG_BLANK;
    end else begin
      drive_q <= drive_next;
    end
  end

  assign bus.an      = drive_q.an;
  assign bus.seg     = drive_q.seg;
  assign bus.ack     = ack_q;
  assign bus.pending = pending_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb/tb_seg7_scan_display.sv - randomized self-checking bench against a frame-level reference model
module tb_seg7_scan_display;

  localparam int DIV_W = 2;
  localparam int SLOT  = 1 << DIV_W;
  localparam int FRAME = 4 * SLOT;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seg7_scan_display_if bus ();

  seg7_scan_display #(.DIV_W(DIV_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [6:0] glyph_tbl [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Reference state: time since reset release, staged/shown words, expected pins.
  int          m_cyc;
  logic [15:0] m_shown;
  logic [15:0] m_stage;
  bit          m_pend;
  bit          m_ack;
  logic [3:0]  m_an;
  logic [7:0]  m_seg;
  int          ack_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  slot;
    bit  boundary;
    if (rst) begin
      m_cyc   = 0;
      m_shown = '0;
      m_stage = '0;
      m_pend  = 0;
      m_ack   = 0;
      m_an    = 4'hF;
      m_seg   = 8'hFF;
    end else begin
      slot = (m_cyc / SLOT) % 4;
      if (bus.blank[slot]) begin
        m_an  = 4'hF;
        m_seg = 8'hFF;
      end else begin
        m_an  = 4'hF & ~(4'(1) << slot);
        m_seg = {~bus.dp[slot], glyph_tbl[4'(m_shown >> (4 * slot))]};
      end
      boundary = (m_cyc % FRAME) == FRAME - 1;
      m_ack = boundary && m_pend;
      if (boundary && m_pend) begin
        m_shown = m_stage;
        m_pend  = 0;
      end
      if (bus.load) begin
        m_stage = bus.num;
        m_pend  = 1;
      end
      m_cyc++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("an", 32'(bus.an), 32'(m_an));
    check("seg", 32'(bus.seg), 32'(m_seg));
    check("ack", 32'(bus.ack), 32'(m_ack));
    check("pending", 32'(bus.pending), 32'(m_pend));
    if (bus.ack === 1'b1) ack_seen++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_load(input logic [15:0] value);
    bus.num  = value;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
  endtask

  // Steps until the next edge is at the given position within the frame.
  task automatic run_until(input int phase);
    for (int i = 0; i < FRAME && (m_cyc % FRAME) != phase; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run(2);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    bus.num   = '0;
    bus.load  = 1'b0;
    bus.dp    = '0;
    bus.blank = '0;

    // Idle scan with zero value.
    do_reset();
    ack_seen = 0;
    run(3 * FRAME);
    check("idle_ack_count", 32'(ack_seen), 32'd0);

    // Mid-frame load, one ack, new glyphs next frame.
    run_until(5);
    ack_seen = 0;
    pulse_load(16'hF8A1);
    run(2 * FRAME);
    check("f8a1_ack_count", 32'(ack_seen), 32'd1);
    check("f8a1_shown", 32'(m_shown), 32'hF8A1);

    // Two loads within one frame: only the last survives.
    run_until(2);
    ack_seen = 0;
    pulse_load(16'h1111);
    run(2);
    pulse_load(16'h2222);
    run(2 * FRAME);
    check("double_ack_count", 32'(ack_seen), 32'd1);

    // Load coinciding with a boundary while another value is pending.
    run_until(3);
    ack_seen = 0;
    pulse_load(16'h3333);
    run_until(FRAME - 1);
    pulse_load(16'h4444);
    check("coincident_pending", 32'(bus.pending), 32'd1);
    run(2 * FRAME);
    check("coincident_ack_count", 32'(ack_seen), 32'd2);

    // Blank digit 2, decimal point on digit 0.
    bus.blank = 4'b0100;
    bus.dp    = 4'b0001;
    run(2 * FRAME);
    bus.blank = 4'b0000;
    bus.dp    = 4'b0000;

    // Reset while a value is pending discards it.
    run_until(4);
    pulse_load(16'h5555);
    run(3);
    ack_seen = 0;
    do_reset();
    run(2 * FRAME);
    check("reset_ack_count", 32'(ack_seen), 32'd0);

    // Random loads and live dp/blank changes.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.num  = 16'($urandom);
        bus.load = 1'b1;
      end
      if ($urandom_range(0, 23) == 0) begin
        bus.dp    = 4'($urandom_range(0, 15));
        bus.blank = 4'($urandom_range(0, 15));
      end
      step();
      bus.load = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
